// File: rtl/dilithium_pkg.sv
// ============================================================================
//  Module      : dilithium_pkg
//  Description : Shared Dilithium constants and types for t0 pack/unpack.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dilithium_pkg;
    localparam int N                  = 256;
    localparam int D                  = 13;
    localparam int T0_OFFSET          = 1 << (D - 1);
    localparam int POLYT0_PACKEDBYTES = N * D / 8;

    typedef logic signed [31:0] coeff_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } unpack_state_t;
endpackage

`default_nettype wire

// File: rtl/polyt0_unpack_stream_if.sv
// ============================================================================
//  Module      : polyt0_unpack_stream_if
//  Description : Byte-in / coefficient-out valid-ready bundle for the t0 unpacker.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface polyt0_unpack_stream_if #(
    parameter int OUTW = 32
);
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [OUTW-1:0] out_coeff;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_coeff, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_coeff, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/polyt0_unpack_stream_t0_coeff_map.sv
// ============================================================================
//  Module      : t0_coeff_map
//  Description : Combinational map of a D-bit packed t0 field to 2^(D-1) - t.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module t0_coeff_map #(
    parameter int D    = 13,
    parameter int OUTW = 32
) (
    input  logic [D-1:0]            i_t,
    output logic signed [OUTW-1:0]  o_coeff
);
    localparam logic signed [OUTW-1:0] c_OFFSET = OUTW'(1 << (D - 1));

    assign o_coeff = c_OFFSET - $signed({{(OUTW-D){1'b0}}, i_t});
endmodule

`default_nettype wire

// File: rtl/polyt0_unpack_stream.sv
// ============================================================================
//  Module      : polyt0_unpack_stream
//  Description : Streaming decoder of the 13-bit packed Dilithium t0 field.
//                Define POLYT0_UNPACK_LAST_CHECK_EN to enable in_last framing check.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module polyt0_unpack_stream
    import dilithium_pkg::*;
#(
    parameter int N    = dilithium_pkg::N,
    parameter int D    = dilithium_pkg::D,
    parameter int OUTW = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    polyt0_unpack_stream_if.slave bus
);
    localparam int c_NBYTES = N * D / 8;
    localparam int c_ACCW   = D + 7;
    localparam int c_BCW    = $clog2(D + 8);
    localparam int c_CNTW   = $clog2(c_NBYTES + 1);

    unpack_state_t             r_state;
    logic [c_ACCW-1:0]         r_acc;
    logic [c_BCW-1:0]          r_bitcnt;
    logic [c_CNTW-1:0]         r_byte_cnt;
    logic [c_CNTW-1:0]         r_coeff_cnt;
    logic                      r_out_valid;
    logic [OUTW-1:0]           r_out_coeff;

    logic                      w_run;
    logic                      w_in_fire;
    logic                      w_emit;
    logic                      w_out_fire;
    logic                      w_last_out;
    logic signed [OUTW-1:0]    w_coeff;

    assign w_run        = (r_state == S_RUN);
    assign bus.in_ready = w_run && (r_bitcnt < c_BCW'(D)) && (r_byte_cnt < c_CNTW'(c_NBYTES));
    assign w_in_fire    = bus.in_valid && bus.in_ready;
    assign w_emit       = w_run && (r_bitcnt >= c_BCW'(D)) && (!r_out_valid || bus.out_ready);
    assign w_out_fire   = r_out_valid && bus.out_ready;
    assign w_last_out   = w_run && w_out_fire && (r_coeff_cnt == c_CNTW'(N));

    assign busy          = w_run;
    assign done          = (r_state == S_DONE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_coeff = r_out_coeff;

    t0_coeff_map #(
        .D    (D),
        .OUTW (OUTW)
    ) u_map (
        .i_t     (r_acc[D-1:0]),
        .o_coeff (w_coeff)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_bitcnt    <= '0;
            r_byte_cnt  <= '0;
            r_coeff_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_coeff <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_acc       <= '0;
                        r_bitcnt    <= '0;
                        r_byte_cnt  <= '0;
                        r_coeff_cnt <= '0;
                    end
                end
                S_RUN: begin
                    // Intake and emit never coincide: one needs bitcnt<D, the other bitcnt>=D.
                    if (w_in_fire) begin
                        r_acc      <= r_acc | (c_ACCW'(bus.in_data) << r_bitcnt);
                        r_bitcnt   <= r_bitcnt + c_BCW'(8);
                        r_byte_cnt <= r_byte_cnt + c_CNTW'(1);
                    end else if (w_emit) begin
                        r_acc       <= r_acc >> D;
                        r_bitcnt    <= r_bitcnt - c_BCW'(D);
                        r_coeff_cnt <= r_coeff_cnt + c_CNTW'(1);
                    end
                    if (w_emit) begin
                        r_out_valid <= 1'b1;
                        r_out_coeff <= w_coeff;
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_last_out) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // 416 bytes carry exactly 256 fields, so nothing may be left over at the end.
    always_ff @(posedge clk) begin
        if (rst_n && w_last_out) begin
            assert (r_bitcnt == '0);
        end
    end

`ifdef POLYT0_UNPACK_LAST_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_err <= 1'b0;
        end else if (w_in_fire) begin
            r_err <= r_err | (bus.in_last != (r_byte_cnt == c_CNTW'(c_NBYTES - 1)));
        end
    end

    assign err = r_err;
`else
    logic w_unused_last;

    assign w_unused_last = bus.in_last;
    assign err           = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_polyt0_unpack_stream.sv
// ============================================================================
//  Module      : tb_polyt0_unpack_stream
//  Description : Self-checking bench for polyt0_unpack_stream against a bit-level pack model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_polyt0_unpack_stream;
    localparam int NB    = 416;
    localparam int NC    = 256;
    localparam int LIMIT = 4000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
    logic err;

    polyt0_unpack_stream_if #(.OUTW(32)) bus ();

    polyt0_unpack_stream #(
        .N    (256),
        .D    (13),
        .OUTW (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  pkt [NB];
    int          exp_c [NC];
    logic [31:0] got [$];
    int          done_cnt, busy_cycles, hs1_cycle, first_valid_cycle, stall_bad, coeffs_at_pause;
    bit          stall_ready_low, timeout;

    // Reference: coefficient c is stored as t = 4096 - c in 13 bits, LSB-first stream.
    task automatic pack_model();
        logic [NB*8-1:0] bits;
        int t;
        bits = '0;
        for (int i = 0; i < NC; i++) begin
            t = 4096 - exp_c[i];
            bits[13*i +: 13] = t[12:0];
        end
        for (int k = 0; k < NB; k++) pkt[k] = bits[8*k +: 8];
    endtask

    task automatic gen_random();
        for (int i = 0; i < NC; i++) exp_c[i] = int'($urandom_range(0, 8191)) - 4095;
        exp_c[0] = -4095;
        exp_c[1] = 4096;
        exp_c[2] = 0;
        pack_model();
    endtask

    task automatic drive_frame(input bit rand_io, input int stall_byte, input int stall_len,
                               input int pause_byte, input int pause_len,
                               input int abort_byte, input int last_pos);
        int bi, cyc, stall_left, pause_left;
        logic [31:0] held;
        bit holding;
        got.delete();
        done_cnt = 0; busy_cycles = 0; hs1_cycle = -1; first_valid_cycle = -1;
        stall_bad = 0; coeffs_at_pause = -1; stall_ready_low = 0; timeout = 0;
        bi = 0; cyc = 0; stall_left = 0; pause_left = 0; holding = 0; held = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        while (cyc < LIMIT) begin
            start         = (cyc == 50);
            bus.in_valid  = (bi < NB) && (pause_left == 0) && (!rand_io || $urandom_range(0, 3) != 0);
            bus.in_data   = pkt[(bi < NB) ? bi : 0];
            bus.in_last   = (bi == last_pos);
            bus.out_ready = (stall_left == 0) && (!rand_io || $urandom_range(0, 4) != 0);
            #1;
            if (done) begin
                done_cnt++;
                break;
            end
            if (busy) busy_cycles++;
            if (holding && (bus.out_valid !== 1'b1 || bus.out_coeff !== held)) stall_bad++;
            holding = bus.out_valid && !bus.out_ready;
            held    = bus.out_coeff;
            if (bus.out_valid === 1'b1 && first_valid_cycle < 0) first_valid_cycle = cyc;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_coeff);
            if (stall_left == 1) stall_ready_low = !bus.in_ready;
            if (pause_left == 1) coeffs_at_pause = got.size();
            if (stall_left > 0) stall_left--;
            if (pause_left > 0) pause_left--;
            if (bus.in_valid && bus.in_ready) begin
                if (bi == 1) hs1_cycle = cyc;
                bi++;
                if (bi == stall_byte) stall_left = stall_len;
                if (bi == pause_byte) pause_left = pause_len;
            end
            cyc++;
            @(negedge clk);
            if (abort_byte > 0 && bi >= abort_byte) break;
        end
        if (cyc >= LIMIT) timeout = 1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, bus.in_ready, bus.out_valid, err} !== 5'b0 || bus.out_coeff !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state got busy/done/rdy/vld/err=%b coeff=%h expected 00000 coeff=0",
                     {busy, done, bus.in_ready, bus.out_valid, err}, bus.out_coeff);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_constant(input logic [7:0] fill, input logic [31:0] expv, input string name);
        for (int k = 0; k < NB; k++) pkt[k] = fill;
        drive_frame(0, -1, 0, -1, 0, 0, 415);
        n_checks++;
        if (timeout || done_cnt != 1 || got.size() != NC) begin
            n_fail++;
            $display("FAIL %s_frame got timeout=%0d done=%0d count=%0d expected 0 1 %0d",
                     name, timeout, done_cnt, got.size(), NC);
        end
        for (int i = 0; i < NC && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== expv) begin
                n_fail++;
                $display("FAIL %s_coeff[%0d] got %h expected %h", name, i, got[i], expv);
            end
        end
        n_checks++;
        if (busy_cycles != 673) begin
            n_fail++;
            $display("FAIL %s_busy_cycles got %0d expected 673", name, busy_cycles);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_err got %b expected 0", name, err);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after_done got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_roundtrip(input bit rand_io);
        gen_random();
        if (rand_io) drive_frame(1, -1, 0, -1, 0, 0, 415);
        else         drive_frame(0, -1, 0, 13, 20, 0, 415);
        n_checks++;
        if (timeout || done_cnt != 1 || got.size() != NC) begin
            n_fail++;
            $display("FAIL roundtrip_frame got timeout=%0d done=%0d count=%0d expected 0 1 %0d",
                     timeout, done_cnt, got.size(), NC);
        end
        for (int i = 0; i < NC && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== 32'(exp_c[i])) begin
                n_fail++;
                $display("FAIL roundtrip_coeff[%0d] got %h expected %h", i, got[i], 32'(exp_c[i]));
            end
        end
        n_checks++;
        if (first_valid_cycle - hs1_cycle != 2) begin
            n_fail++;
            $display("FAIL first_valid_latency got %0d expected 2", first_valid_cycle - hs1_cycle);
        end
        n_checks++;
        if (stall_bad != 0) begin
            n_fail++;
            $display("FAIL roundtrip_hold got %0d unstable cycles expected 0", stall_bad);
        end
        if (!rand_io) begin
            n_checks++;
            if (coeffs_at_pause != 8) begin
                n_fail++;
                $display("FAIL first13_bytes got %0d coeffs expected 8", coeffs_at_pause);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        gen_random();
        drive_frame(0, 200, 10, -1, 0, 0, 415);
        n_checks++;
        if (stall_bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold got %0d unstable cycles expected 0", stall_bad);
        end
        n_checks++;
        if (!stall_ready_low) begin
            n_fail++;
            $display("FAIL bp_in_ready got 1 expected 0 during stall");
        end
        n_checks++;
        if (timeout || got.size() != NC) begin
            n_fail++;
            $display("FAIL bp_count got %0d expected %0d", got.size(), NC);
        end
        for (int i = 0; i < NC && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== 32'(exp_c[i])) begin
                n_fail++;
                $display("FAIL bp_coeff[%0d] got %h expected %h", i, got[i], 32'(exp_c[i]));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int dn;
        gen_random();
        drive_frame(0, -1, 0, -1, 0, 100, 415);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, bus.in_ready, bus.out_valid, err} !== 5'b0 || bus.out_coeff !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_state got busy/done/rdy/vld/err=%b coeff=%h expected 00000 coeff=0",
                     {busy, done, bus.in_ready, bus.out_valid, err}, bus.out_coeff);
        end
        rst_n = 1'b1;
        dn = done_cnt;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        n_checks++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL midreset_done got %0d pulses expected 0", dn);
        end
        test_roundtrip(1'b0);
    endtask

`ifdef POLYT0_UNPACK_LAST_CHECK_EN
    task automatic test_last_check();
        gen_random();
        drive_frame(0, -1, 0, -1, 0, 0, 300);
        n_checks++;
        if (err !== 1'b1 || got.size() != NC) begin
            n_fail++;
            $display("FAIL last_early got err=%b count=%0d expected 1 %0d", err, got.size(), NC);
        end
        @(negedge clk);
        drive_frame(0, -1, 0, -1, 0, 0, 415);
        n_checks++;
        if (err !== 1'b0 || got.size() != NC) begin
            n_fail++;
            $display("FAIL last_ok got err=%b count=%0d expected 0 %0d", err, got.size(), NC);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_constant(8'h00, 32'h0000_1000, "zeros");
        test_constant(8'hFF, 32'hFFFF_F001, "ones");
        test_roundtrip(1'b0);
        test_roundtrip(1'b1);
        test_backpressure();
        test_reset_midframe();
`ifdef POLYT0_UNPACK_LAST_CHECK_EN
        test_last_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
